fetch: RTL

- Front-end instruction fetch stage that feeds the execution stage with {pc, inst} beats.
- Owns the architectural fetch PC and issues in-order, pipelined requests to a req/gnt/rvalid instruction memory port.
- Buffers returned words in a small queue.
- Consumes the execution stage's branch redirect (pc_v_x/pc_x), squashing all wrong-path requests and buffered words.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INST_BYTES       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} beats; flush wins over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 32'd1) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, issues pipelined req/gnt/rvalid
// reads, buffers returned words and squashes wrong-path traffic on redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [2:0]      outst_q, outst_d;
    logic [2:0]      squash_q, squash_d;
    logic [31:0]     last_pc_q, last_pc_d;
    logic [31:0]     last_inst_q, last_inst_d;

    logic            run, redirect, fire, push, pop, q_nonempty;
    logic [31:0]     target, credit;
    logic [CntW-1:0] q_count;
    fetch_entry_t    q_head, push_data;
    logic            unused_pc_lsb;

    assign run           = (state_q == StRun);
    assign redirect      = run & redirect_v_i;
    assign target        = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign q_nonempty    = (q_count != '0);

    // Live (non-squashed) in-flight words plus buffered words must fit the queue.
    assign credit     = 32'(outst_q) - 32'(squash_q) + 32'(q_count);
    assign imem_req_o = run & ~redirect_v_i & (32'(outst_q) < MAX_OUTSTANDING)
                        & (credit < QUEUE_DEPTH);
    assign imem_addr_o = fetch_pc_q;
    assign fire        = imem_req_o & imem_gnt_i;

    assign push      = imem_rvalid_i & (squash_q == '0) & ~redirect;
    assign push_data = '{pc: resp_pc_q, inst: imem_rdata_i};

    assign inst_v_o = q_nonempty & ~hold_i & ~redirect_v_i;
    assign pop      = inst_v_o;
    assign pc_o     = q_nonempty ? q_head.pc : last_pc_q;
    assign inst_o   = q_nonempty ? q_head.inst : last_inst_q;

    always_comb begin
        state_d     = StRun;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        last_pc_d   = last_pc_q;
        last_inst_d = last_inst_q;
        squash_d    = squash_q;
        outst_d     = outst_q + 3'(fire) - 3'(imem_rvalid_i);

        if (imem_rvalid_i && squash_q != '0) squash_d = squash_q - 3'd1;
        if (fire) fetch_pc_d = fetch_pc_q + INST_BYTES;
        if (push) resp_pc_d = resp_pc_q + INST_BYTES;
        if (pop) begin
            last_pc_d   = q_head.pc;
            last_inst_d = q_head.inst;
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect) begin
            squash_d   = outst_d;
            fetch_pc_d = target;
            resp_pc_d  = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StBoot;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            outst_q     <= '0;
            squash_q    <= '0;
            last_pc_q   <= RESET_PC;
            last_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            outst_q     <= outst_d;
            squash_q    <= squash_d;
            last_pc_q   <= last_pc_d;
            last_inst_q <= last_inst_d;
        end
    end

    fetch_queue #(
        .Depth(QUEUE_DEPTH)
    ) u_queue (
        .clk_i      (clk),
        .rst_i      (reset),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .flush_i    (redirect),
        .count_o    (q_count),
        .head_o     (q_head)
    );

    assert property (@(posedge clk) disable iff (reset) imem_rvalid_i |-> (outst_q != '0))
        else $error("fetch: rvalid with no outstanding request");

endmodule
